// File: rtl/fxp_pkg.sv
// Shared fixed-point maths types and helpers for the multiplier and divider.
// No latency or backpressure of its own; pure declarations and functions.
// Widths are handled at a fixed maximum and narrowed by the caller.
package fxp_pkg;

    localparam int MAXW = 64;

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        CALC,
        ROUND,
        SIGN
    } state_t;

    // Most negative two's-complement value of a w-bit word; it has no positive counterpart.
    function automatic logic [MAXW-1:0] smallest(input int w);
        return MAXW'(1) << (w - 1);
    endfunction

    // Round half to even; the bit above the caller's width is the carry-out.
    function automatic logic [MAXW:0] gauss_round(input logic [MAXW-1:0] r,
                                                  input logic guard,
                                                  input logic sticky);
        logic up;
        up = guard & (r[0] | sticky);
        return {1'b0, r} + (MAXW + 1)'(up);
    endfunction

endpackage

// File: rtl/fxp_mul.sv
// Sequential signed fixed-point multiplier, one shift-add step per magnitude bit.
// Latency: done pulses WIDTH+2 edges after the start edge; 0 extra edges for a SMALLEST operand.
// Backpressure: none; start is only honoured in IDLE and ignored while busy.
module fxp_mul
    import fxp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int FBITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             ovf,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] val
);

    localparam int WIDTHU = WIDTH - 1;
    localparam int PW     = 2 * WIDTHU;
    localparam int CW     = $clog2(WIDTHU) + 1;
    localparam logic [WIDTH-1:0] SMALLEST = WIDTH'(smallest(WIDTH));
    localparam logic [CW-1:0]    LAST     = CW'(WIDTHU - 1);

    state_t state, state_nxt;

    logic [WIDTHU-1:0] au, bu, r_q;
    logic              sig_diff;
    logic [PW-1:0]     prod;
    logic [CW-1:0]     i;

    logic              small_in;
    logic [PW+1:0]     pext;
    logic [WIDTHU-1:0] r_fld;
    logic              guard, sticky, hi_nz;
    logic [WIDTHU:0]   rnd;

    assign small_in = (a == SMALLEST) || (b == SMALLEST);

    // Two zero bits below prod make guard/sticky well defined for FBITS of 0 or 1.
    assign pext   = {prod, 2'b00};
    assign r_fld  = pext[FBITS+2 +: WIDTHU];
    assign guard  = pext[FBITS+1];
    assign sticky = |pext[FBITS:0];
    assign hi_nz  = |(pext >> (FBITS + 2 + WIDTHU));
    assign rnd    = (WIDTHU + 1)'(gauss_round(MAXW'(r_fld), guard, sticky));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && !small_in) state_nxt = INIT;
            INIT:    state_nxt = CALC;
            CALC:    if (i == LAST) state_nxt = ROUND;
            ROUND:   state_nxt = SIGN;
            SIGN:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
            ovf      <= 1'b0;
            val      <= '0;
            au       <= '0;
            bu       <= '0;
            r_q      <= '0;
            sig_diff <= 1'b0;
            prod     <= '0;
            i        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        valid <= 1'b0;
                        if (small_in) begin
                            ovf  <= 1'b1;
                            done <= 1'b1;
                        end else begin
                            au       <= WIDTHU'(a[WIDTH-1] ? -a : a);
                            bu       <= WIDTHU'(b[WIDTH-1] ? -b : b);
                            sig_diff <= a[WIDTH-1] ^ b[WIDTH-1];
                            busy     <= 1'b1;
                            ovf      <= 1'b0;
                        end
                    end
                end
                INIT: begin
                    prod <= '0;
                    i    <= '0;
                end
                CALC: begin
                    // bu is shifted left so its MSB is always the current multiplier bit.
                    prod <= (prod << 1) + (bu[WIDTHU-1] ? PW'(au) : '0);
                    bu   <= bu << 1;
                    i    <= i + 1'b1;
                end
                ROUND: begin
                    r_q <= rnd[WIDTHU-1:0];
                    ovf <= hi_nz | rnd[WIDTHU];
                end
                SIGN: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (!ovf) begin
                        valid <= 1'b1;
                        if (r_q == '0) val <= '0;
                        else if (sig_diff) val <= {1'b1, WIDTHU'(-r_q)};
                        else val <= {1'b0, r_q};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
